// File: rtl/frame_deserializer.sv
// Packs a serial bit stream into WORD_W-bit words (MSB first) and flags frame completion or error.
// Optional even-parity trailer bit enabled with `define FRAME_PARITY_CHECK_EN.
module frame_deserializer #(
  parameter int WORD_W     = 8,
  parameter int FRAME_BITS = 97,
  parameter int CNT_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxBit,
  input  logic              rxValid,
  input  logic              rxAbort,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  output logic              frameDone,
  output logic              frameErr,
  output logic [CNT_W-1:0]  bitCount
);

  localparam int                IDX_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BITS);
  localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

  state_t             r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_count;
  logic               r_word_valid;
  logic               r_done;
  logic               r_err;
`ifdef FRAME_PARITY_CHECK_EN
  logic               r_par;
`endif

  logic               w_accept;
  logic               w_last;
  logic [WORD_W-1:0]  w_shift_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_accept    = rxValid & ~rxAbort;
  assign w_shift_nxt = {r_shift[WORD_W-2:0], rxBit};
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_cnt_nxt   = r_count + 1'b1;
  assign w_last      = (w_cnt_nxt == LAST_CNT);

  // The shift register is cleared after every emitted word, so a partial word is already right-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_count      <= '0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef FRAME_PARITY_CHECK_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (r_state == COLLECT && (rxAbort || !rxValid)) begin
            r_err   <= 1'b1;
            r_shift <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_state <= IDLE;
`ifdef FRAME_PARITY_CHECK_EN
            r_par   <= 1'b0;
`endif
          end else if (w_accept) begin
            r_count <= w_cnt_nxt;
`ifdef FRAME_PARITY_CHECK_EN
            if (w_last) begin
              // Trailer bit is parity only; flush whatever data bits remain.
              if (r_idx != '0) begin
                r_word       <= r_shift;
                r_word_valid <= 1'b1;
              end
              r_done  <= (r_par == rxBit);
              r_err   <= (r_par != rxBit);
              r_shift <= '0;
              r_idx   <= '0;
              r_par   <= 1'b0;
              r_state <= FLUSH;
            end else begin
              r_par <= r_par ^ rxBit;
              if (w_idx_nxt == IDX_FULL) begin
                r_word       <= w_shift_nxt;
                r_word_valid <= 1'b1;
                r_shift      <= '0;
                r_idx        <= '0;
              end else begin
                r_shift <= w_shift_nxt;
                r_idx   <= w_idx_nxt;
              end
              r_state <= COLLECT;
            end
`else
            if (w_last) begin
              r_word       <= w_shift_nxt;
              r_word_valid <= 1'b1;
              r_done       <= 1'b1;
              r_shift      <= '0;
              r_idx        <= '0;
              r_state      <= FLUSH;
            end else if (w_idx_nxt == IDX_FULL) begin
              r_word       <= w_shift_nxt;
              r_word_valid <= 1'b1;
              r_shift      <= '0;
              r_idx        <= '0;
              r_state      <= COLLECT;
            end else begin
              r_shift <= w_shift_nxt;
              r_idx   <= w_idx_nxt;
              r_state <= COLLECT;
            end
`endif
          end
        end
        FLUSH: begin
          r_count <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wordOut   = r_word;
  assign wordValid = r_word_valid;
  assign frameDone = r_done;
  assign frameErr  = r_err;
  assign bitCount  = r_count;

endmodule
